// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused LSB-first across WIDTH cycles.
// Optional subtract mode when SERIAL_SUB_EN is defined (adds the op port).
module tran_full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, last_bit;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_SUB_EN
  // Subtract as a + ~b + 1; cin is ignored in that mode.
  assign b_load     = op ? ~b : b;
  assign carry_load = op ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = in_valid && in_ready;

  tran_full_adder u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_co;
      // Saturate on the final bit so the counter never wraps.
      if (!last_bit) cnt <= cnt + CW'(1);
    end
  end

  assign sum  = sum_sh;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: driver pushes expected results,
// a negedge monitor pops and compares on each result handshake.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int errors = 0;
  int checks = 0;
  logic [W:0] sb[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mcin, input logic mop);
    longint unsigned r;
    logic [W-1:0] d;
    if (mop) begin
      d = W'(longint'(ma) - longint'(mb));
      return {(ma >= mb), d};
    end
    r = longint'(ma) + longint'(mb) + longint'(mcin);
    return r[W:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("result_unexpected", {cout, sum}, '0);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        check("result", {cout, sum}, e);
      end
    end
  end

  task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                     input logic top, input int hold, input bit pulse);
    int lat;
    logic [W-1:0] hs;
    logic hc;
    logic eop;
`ifdef SERIAL_SUB_EN
    eop = top;
`else
    eop = 1'b0;
`endif
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb_; cin = tcin; op = top;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    sb.push_back(model(ta, tb_, tcin, eop));
    #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    for (int k = 1; k <= int'(W) + 4; k++) begin
      @(posedge clk); #1;
      in_valid = pulse && (k == 2);
      if (in_valid) begin a = W'($urandom); b = W'($urandom); end
      @(negedge clk);
      if (pulse && k == 2) check("in_ready_run", in_ready, 0);
      if (out_valid) begin lat = k; break; end
    end
    in_valid = 1'b0;
    check("latency", lat, W);
    hs = sum; hc = cout;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", {cout, sum}, {hc, hs});
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("idle_after", {in_ready, busy, out_valid}, 3'b100);
    check("result_kept", {cout, sum}, {hc, hs});
  endtask

  initial begin
    logic sub;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {in_ready, out_valid, busy, cout}, 4'b1000);
    check("rst_sum", sum, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_flags", {in_ready, out_valid, busy, cout}, 4'b1000);
    check("rel_sum", sum, 0);

    txn(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 0);
    txn(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
    txn(8'h00, 8'h00, 1'b1, 1'b0, 0, 0);
    txn(8'h12, 8'h34, 1'b1, 1'b0, 5, 1);

    // Reset three cycles into RUN: transaction is discarded.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'hAB; b = 8'hCD; cin = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {in_ready, out_valid, busy, cout}, 4'b1000);
    check("mid_rst_sum", sum, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    txn(8'h01, 8'h01, 1'b0, 1'b0, 0, 0);

`ifdef SERIAL_SUB_EN
    txn(8'h10, 8'h01, 1'b0, 1'b1, 0, 0);
    txn(8'h00, 8'h01, 1'b1, 1'b1, 0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      sub = 1'($urandom);
      txn(W'($urandom), W'($urandom), 1'($urandom), sub,
          int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
